// File: rtl/uart_alu_if.sv
// Frame sequencer between the UART and a combinational ALU: collects A, B and
// opcode bytes, registers them for the ALU, and hands the result to the UART tx.
module uart_alu_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 50000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    input  logic                  tx_done,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [5:0]            alu_op,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    output logic                  busy,
    output logic                  timeout,
    output logic                  overrun
);

    localparam int unsigned   CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        COMPUTE,
        SEND,
        WAIT_TX
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [5:0]            r_alu_op;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_start;
    logic                  r_busy;
    logic                  r_timeout;
    logic                  r_overrun;
    logic                  w_load_a;
    logic                  w_load_b;
    logic                  w_load_op;
    logic                  w_load_tx;
    logic                  w_timeout_nxt;
    logic                  w_overrun_nxt;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_load_a      = 1'b0;
        w_load_b      = 1'b0;
        w_load_op     = 1'b0;
        w_load_tx     = 1'b0;
        w_timeout_nxt = 1'b0;
        w_overrun_nxt = 1'b0;
        case (r_state)
            WAIT_A: begin
                if (rx_done) begin
                    w_load_a    = 1'b1;
                    w_state_nxt = WAIT_B;
                end
            end
            WAIT_B, WAIT_OP: begin
                // A byte landing on the expiry cycle is accepted, not timed out.
                if (rx_done) begin
                    w_load_b    = (r_state == WAIT_B);
                    w_load_op   = (r_state == WAIT_OP);
                    w_state_nxt = (r_state == WAIT_B) ? WAIT_OP : COMPUTE;
                end else if ((TIMEOUT != 0) && (r_cnt == LIMIT)) begin
                    w_state_nxt   = WAIT_A;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            COMPUTE: begin
                w_load_tx     = 1'b1;
                w_overrun_nxt = rx_done;
                w_state_nxt   = SEND;
            end
            SEND: begin
                w_overrun_nxt = rx_done;
                w_state_nxt   = WAIT_TX;
            end
            WAIT_TX: begin
                w_overrun_nxt = rx_done;
                if (tx_done) w_state_nxt = WAIT_A;
            end
            default: w_state_nxt = WAIT_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= WAIT_A;
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
            r_overrun  <= w_overrun_nxt;
            // Flags follow the next state so they line up with the state itself.
            r_tx_start <= (w_state_nxt == SEND);
            r_busy     <= (w_state_nxt == COMPUTE) || (w_state_nxt == SEND) ||
                          (w_state_nxt == WAIT_TX);
            if (w_load_a)  r_alu_a   <= rx_data;
            if (w_load_b)  r_alu_b   <= rx_data;
            if (w_load_op) r_alu_op  <= rx_data[5:0];
            if (w_load_tx) r_tx_data <= alu_result;
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign busy     = r_busy;
    assign timeout  = r_timeout;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed bench for uart_alu_if with a small behavioural ALU attached.
module tb_uart_alu_if;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       timeout;
    logic       overrun;

    int n_tests;
    int n_fail;

    uart_alu_if #(.DATA_WIDTH(8), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_done    (tx_done),
        .alu_result (alu_result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .timeout    (timeout),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h25:   alu_result = alu_a | alu_b;
            6'h03:   alu_result = $unsigned($signed(alu_a) >>> alu_b);
            default: alu_result = 8'h00;
        endcase
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx();
        @(negedge clk);
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
    endtask

    // Runs a whole frame through to tx_done and reports what was observed.
    task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            output logic [7:0] o_a, output logic [7:0] o_b,
                            output logic [5:0] o_op, output logic [7:0] o_tx,
                            output logic start_ok, output logic busy_ok);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        start_ok = (tx_start === 1'b0);
        busy_ok  = (busy === 1'b1);
        @(posedge clk); #1;
        start_ok = start_ok && (tx_start === 1'b1);
        busy_ok  = busy_ok && (busy === 1'b1);
        o_tx     = tx_data;
        @(posedge clk); #1;
        start_ok = start_ok && (tx_start === 1'b0);
        busy_ok  = busy_ok && (busy === 1'b1);
        o_a      = alu_a;
        o_b      = alu_b;
        o_op     = alu_op;
        pulse_tx();
        busy_ok  = busy_ok && (busy === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, timeout, overrun} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got a=%h b=%h op=%h tx=%h st=%b bz=%b to=%b ov=%b, want all 0",
                     alu_a, alu_b, alu_op, tx_data, tx_start, busy, timeout, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_ops();
        logic [7:0] oa, ob, otx;
        logic [5:0] oop;
        logic       s_ok, b_ok;
        do_frame(8'h05, 8'h03, 8'h20, oa, ob, oop, otx, s_ok, b_ok);
        n_tests++;
        if ({oa, ob, oop} !== {8'h05, 8'h03, 6'h20}) begin
            n_fail++;
            $display("FAIL add_operands: got %h %h %h, want 05 03 20", oa, ob, oop);
        end
        n_tests++;
        if (otx !== 8'h08) begin n_fail++; $display("FAIL add_result: got %h, want 08", otx); end
        n_tests++;
        if (s_ok !== 1'b1) begin n_fail++; $display("FAIL add_tx_start_timing: got %b, want 1", s_ok); end
        n_tests++;
        if (b_ok !== 1'b1) begin n_fail++; $display("FAIL add_busy_window: got %b, want 1", b_ok); end

        do_frame(8'h03, 8'h05, 8'h22, oa, ob, oop, otx, s_ok, b_ok);
        n_tests++;
        if (otx !== 8'hFE) begin n_fail++; $display("FAIL sub_result: got %h, want fe", otx); end

        do_frame(8'hF0, 8'h02, 8'hC3, oa, ob, oop, otx, s_ok, b_ok);
        n_tests++;
        if (oop !== 6'h03) begin n_fail++; $display("FAIL op_mask: got %h, want 03", oop); end
        n_tests++;
        if (otx !== 8'hFC) begin n_fail++; $display("FAIL sra_result: got %h, want fc", otx); end
    endtask

    task automatic test_timeout();
        logic [7:0] oa, ob, otx;
        logic [5:0] oop;
        logic       s_ok, b_ok;
        logic       early;
        send_byte(8'h11);
        early = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (timeout !== 1'b0) early = 1'b1;
        end
        n_tests++;
        if (early !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b, want 0", early); end
        @(posedge clk); #1;
        n_tests++;
        if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: got %b, want 1", timeout); end
        @(posedge clk); #1;
        n_tests++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_one_cycle: got %b, want 0", timeout); end
        do_frame(8'h01, 8'h01, 8'h20, oa, ob, oop, otx, s_ok, b_ok);
        n_tests++;
        if ({oa, otx} !== {8'h01, 8'h02}) begin
            n_fail++;
            $display("FAIL timeout_resync: got a=%h tx=%h, want a=01 tx=02", oa, otx);
        end

        // A byte on the expiry cycle is accepted instead of timing out.
        send_byte(8'h06);
        repeat (15) @(posedge clk);
        #1;
        send_byte(8'h07);
        n_tests++;
        if ({timeout, alu_b} !== {1'b0, 8'h07}) begin
            n_fail++;
            $display("FAIL expiry_byte_wins: got to=%b b=%h, want to=0 b=07", timeout, alu_b);
        end
        send_byte(8'h20);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (tx_data !== 8'h0D) begin n_fail++; $display("FAIL expiry_frame_result: got %h, want 0d", tx_data); end
        pulse_tx();
    endtask

    task automatic test_overrun();
        logic [7:0] oa, ob, otx;
        logic [5:0] oop;
        logic       s_ok, b_ok;
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'h77);
        n_tests++;
        if ({overrun, alu_a, busy} !== {1'b1, 8'h05, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun_wait_tx: got ov=%b a=%h bz=%b, want ov=1 a=05 bz=1", overrun, alu_a, busy);
        end
        @(posedge clk); #1;
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_one_cycle: got %b, want 0", overrun); end
        pulse_tx();

        send_byte(8'h0A);
        pulse_tx();
        n_tests++;
        if ({tx_start, busy, overrun} !== 3'b000) begin
            n_fail++;
            $display("FAIL tx_done_in_wait_b: got st=%b bz=%b ov=%b, want 000", tx_start, busy, overrun);
        end
        send_byte(8'h0B);
        send_byte(8'h20);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({alu_a, alu_b, tx_data} !== {8'h0A, 8'h0B, 8'h15}) begin
            n_fail++;
            $display("FAIL wait_b_kept: got a=%h b=%h tx=%h, want 0a 0b 15", alu_a, alu_b, tx_data);
        end
        pulse_tx();
        do_frame(8'h00, 8'h00, 8'h00, oa, ob, oop, otx, s_ok, b_ok);
    endtask

    task automatic test_async_reset();
        logic [7:0] oa, ob, otx;
        logic [5:0] oop;
        logic       s_ok, b_ok;
        send_byte(8'h09);
        send_byte(8'h04);
        send_byte(8'h20);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, timeout, overrun} !== 42'd0) begin
            n_fail++;
            $display("FAIL async_reset: got a=%h b=%h op=%h tx=%h st=%b bz=%b, want all 0",
                     alu_a, alu_b, alu_op, tx_data, tx_start, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_tx();
        @(posedge clk); #1;
        n_tests++;
        if ({tx_start, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL tx_done_after_reset: got st=%b bz=%b, want 00", tx_start, busy);
        end
        do_frame(8'h02, 8'h03, 8'h20, oa, ob, oop, otx, s_ok, b_ok);
        n_tests++;
        if ({oa, otx, s_ok, b_ok} !== {8'h02, 8'h05, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL frame_after_reset: got a=%h tx=%h st_ok=%b bz_ok=%b, want 02 05 1 1",
                     oa, otx, s_ok, b_ok);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] oa, ob, otx;
        logic [5:0] oop;
        logic       s_ok, b_ok;
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rx_data = 8'h33;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        tx_done = 1'b0;
        n_tests++;
        if ({overrun, busy, tx_start, alu_a} !== {3'b100, 8'h05}) begin
            n_fail++;
            $display("FAIL rx_tx_same_cycle: got ov=%b bz=%b st=%b a=%h, want 1 0 0 05",
                     overrun, busy, tx_start, alu_a);
        end
        do_frame(8'h0F, 8'hF0, 8'h25, oa, ob, oop, otx, s_ok, b_ok);
        n_tests++;
        if ({oa, ob, otx} !== {8'h0F, 8'hF0, 8'hFF}) begin
            n_fail++;
            $display("FAIL or_after_b2b: got a=%h b=%h tx=%h, want 0f f0 ff", oa, ob, otx);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        test_reset();
        test_alu_ops();
        test_timeout();
        test_overrun();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_alu_if.md
Name: uart_alu_if

Overview:
- Sequencing stage between the UART receiver/transmitter and the combinational ALU.
- Collects three received bytes in order: operand A, operand B, opcode.
- Drives them as stable registered inputs to the ALU, captures the ALU result, and hands it to the UART transmitter with a start/done handshake.
- An inter-byte timeout resynchronises the frame if the host stalls mid-sequence.

Parameters:
- DATA_WIDTH, 8: operand/result width; equals the UART word width.
- TIMEOUT, 50000000: clk cycles allowed between bytes of one frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  DATA_WIDTH  received byte; valid when rx_done=1
- rx_done  in  1  one-cycle pulse from UART rx
- tx_done  in  1  one-cycle pulse from UART tx when the frame is sent
- alu_result  in  DATA_WIDTH  ALU output (combinational from alu_a/alu_b/alu_op)
- alu_a  out  DATA_WIDTH  operand A register
- alu_b  out  DATA_WIDTH  operand B register
- alu_op  out  6  opcode register
- tx_data  out  DATA_WIDTH  result byte to UART tx
- tx_start  out  1  one-cycle transmit request
- busy  out  1  high in COMPUTE, SEND, WAIT_TX
- timeout  out  1  one-cycle pulse when a frame is abandoned
- overrun  out  1  one-cycle pulse when an rx byte is dropped

Behaviour:
- Reset (async, rst_n=0):
  - state=WAIT_A.
  - alu_a, alu_b, alu_op, tx_data = 0.
  - tx_start, busy, timeout, overrun = 0.
  - Timeout counter = 0.
  - Reset mid-frame or mid-transmit discards all progress. A tx_done arriving after reset is ignored.
- WAIT_A: on rx_done, alu_a<=rx_data, go to WAIT_B.
- WAIT_B: on rx_done, alu_b<=rx_data, go to WAIT_OP.
- WAIT_OP: on rx_done, alu_op<=rx_data[5:0] (bits above 5 ignored), go to COMPUTE.
- COMPUTE: exactly one cycle; tx_data<=alu_result; go to SEND.
- SEND: exactly one cycle; go to WAIT_TX.
- WAIT_TX: on tx_done, go to WAIT_A.
- tx_start:
  - Registered; high for exactly the one cycle in which state==SEND.
  - Latency: the clk edge sampling the opcode's rx_done is E0. tx_data is valid after E1. tx_start is high from E1 to E2.
- busy: registered; high in COMPUTE, SEND, WAIT_TX.
- Operand stability:
  - alu_a/alu_b/alu_op change only on their own capture edge.
  - They hold their values through SEND/WAIT_TX and until overwritten by the next frame.
  - tx_data holds until the next COMPUTE.
- Timeout counter:
  - Cleared on every accepted byte and in WAIT_A, COMPUTE, SEND, WAIT_TX.
  - Increments each cycle in WAIT_B/WAIT_OP without rx_done.
  - When it reaches TIMEOUT-1 without rx_done: state<=WAIT_A, timeout pulses one cycle, counter clears. Captured registers are left as is.
  - rx_done in the same cycle as expiry wins: the byte is accepted and no timeout occurs.
  - TIMEOUT=0: the counter never expires.
- rx_done while busy: byte discarded, overrun pulses one cycle, state unchanged.
- tx_done outside WAIT_TX: ignored, no flag.
- rx_done and tx_done in the same cycle in WAIT_TX: go to WAIT_A, byte discarded, overrun pulses.
- No arithmetic in this block; widths pass straight through.

Test Plan:
- Reset then rx bytes 0x05, 0x03, 0x20 (ADD), ALU model attached -> alu_a=0x05, alu_b=0x03, alu_op=6'h20; tx_data=0x08; tx_start high exactly 1 cycle, 2 edges after the opcode rx_done; busy high until tx_done.
- Bytes 0x03, 0x05, 0x22 (SUB) -> tx_data=0xFE. Then bytes 0xF0, 0x02, 0xC3 -> alu_op=6'h03, tx_data=0xFC (arithmetic shift right); bits 7:6 of opcode ignored.
- TIMEOUT=16: send 0x11, then no byte for 16 cycles -> timeout pulse on cycle 15, state back to WAIT_A; the next 3 bytes 0x01, 0x01, 0x20 -> tx_data=0x02.
- During WAIT_TX send rx_done with 0x77 -> overrun 1 cycle, alu_a unchanged. Inject tx_done while in WAIT_B -> ignored, state stays WAIT_B.
- Assert rst_n=0 asynchronously mid-WAIT_TX (between clk edges) -> all outputs 0 immediately. A later tx_done produces no tx_start; a fresh 3-byte frame completes normally.
- Back-to-back frames, opcode rx_done in the same cycle as tx_done in WAIT_TX -> state WAIT_A, overrun pulse. Following frame 0x0F, 0xF0, 0x25 (OR) -> tx_data=0xFF.
